// File: rtl/stopwatch_ctrl.sv
// Stopwatch front panel: button sync/debounce, run/lap FSM and display path.
// Optional `STOPWATCH_CTRL_AUTOSTOP_EN halts the timer at 59:59 instead of wrapping.
module stopwatch_ctrl #(
    parameter int DEB_CYCLES = 500000,
    parameter int DEB_W      = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_ss,
    input  logic       btn_lap,
    input  logic [5:0] sec_in,
    input  logic [5:0] min_in,
    output logic       sw_start,
    output logic       sw_stop,
    output logic       sw_clear,
    output logic [5:0] disp_sec,
    output logic [5:0] disp_min,
    output logic       lap_active,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        LAP    = 2'd2,
        PAUSED = 2'd3
    } state_t;

    state_t state_q, state_n;

    // index 0 = start/stop, index 1 = lap/clear
    logic [1:0]            sync1, sync2, stable, stable_d;
    logic [1:0][DEB_W-1:0] deb_cnt;
    logic [1:0]            press;

    logic       ss_ev, lap_ev, at_limit;
    logic       start_n, stop_n, clear_n, snap;
    logic [5:0] lap_sec, lap_min;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1    <= '0;
            sync2    <= '0;
            stable   <= '0;
            stable_d <= '0;
            deb_cnt  <= '0;
        end else begin
            sync1    <= {btn_lap, btn_ss};
            sync2    <= sync1;
            stable_d <= stable;
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] == stable[i]) begin
                    deb_cnt[i] <= '0;
                end else if (deb_cnt[i] == DEB_W'(DEB_CYCLES - 1)) begin
                    stable[i]  <= sync2[i];
                    deb_cnt[i] <= '0;
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign press  = stable & ~stable_d;
    assign ss_ev  = press[0];
    assign lap_ev = press[1];

`ifdef STOPWATCH_CTRL_AUTOSTOP_EN
    assign at_limit = (sec_in == 6'd59) && (min_in == 6'd59);
`else
    assign at_limit = 1'b0;
`endif

    always_comb begin
        state_n = state_q;
        start_n = 1'b0;
        stop_n  = 1'b0;
        clear_n = 1'b0;
        snap    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (ss_ev) begin
                    start_n = 1'b1;
                    state_n = RUN;
                end else if (lap_ev) begin
                    clear_n = 1'b1;
                end
            end
            RUN: begin
                if (at_limit || ss_ev) begin
                    stop_n  = 1'b1;
                    state_n = PAUSED;
                end else if (lap_ev) begin
                    snap    = 1'b1;
                    state_n = LAP;
                end
            end
            LAP: begin
                if (at_limit || ss_ev) begin
                    stop_n  = 1'b1;
                    state_n = PAUSED;
                end else if (lap_ev) begin
                    state_n = RUN;
                end
            end
            PAUSED: begin
                if (ss_ev) begin
                    start_n = 1'b1;
                    state_n = RUN;
                end else if (lap_ev) begin
                    clear_n = 1'b1;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            sw_start   <= 1'b0;
            sw_stop    <= 1'b0;
            sw_clear   <= 1'b0;
            lap_active <= 1'b0;
            lap_sec    <= '0;
            lap_min    <= '0;
            disp_sec   <= '0;
            disp_min   <= '0;
        end else begin
            state_q    <= state_n;
            sw_start   <= start_n;
            sw_stop    <= stop_n;
            sw_clear   <= clear_n;
            lap_active <= (state_n == LAP);
            if (snap) begin
                lap_sec <= sec_in;
                lap_min <= min_in;
            end
            if (state_q == LAP) begin
                disp_sec <= lap_sec;
                disp_min <= lap_min;
            end else begin
                disp_sec <= sec_in;
                disp_min <= min_in;
            end
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with DEB_CYCLES=4.
// Build with +define+STOPWATCH_CTRL_AUTOSTOP_EN to cover the 59:59 stop.
module tb_stopwatch_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       btn_ss, btn_lap;
    logic [5:0] sec_in, min_in;
    logic       sw_start, sw_stop, sw_clear;
    logic [5:0] disp_sec, disp_min;
    logic       lap_active;
    logic [1:0] state;

    int n_chk  = 0;
    int n_fail = 0;
    int n_st, n_sp, n_cl;

    stopwatch_ctrl #(
        .DEB_CYCLES(4),
        .DEB_W(20)
    ) dut (
        .clk(clk),
        .rst(rst),
        .btn_ss(btn_ss),
        .btn_lap(btn_lap),
        .sec_in(sec_in),
        .min_in(min_in),
        .sw_start(sw_start),
        .sw_stop(sw_stop),
        .sw_clear(sw_clear),
        .disp_sec(disp_sec),
        .disp_min(disp_min),
        .lap_active(lap_active),
        .state(state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Hold the chosen buttons through debounce, release, and tally pulses.
    task automatic press(input logic ss, input logic lp,
                         output int st, output int sp, output int cl);
        st = 0; sp = 0; cl = 0;
        @(negedge clk);
        btn_ss  = ss;
        btn_lap = lp;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            st += int'(sw_start);
            sp += int'(sw_stop);
            cl += int'(sw_clear);
        end
        @(negedge clk);
        btn_ss  = 1'b0;
        btn_lap = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            st += int'(sw_start);
            sp += int'(sw_stop);
            cl += int'(sw_clear);
        end
    endtask

    initial begin
        rst = 1'b1;
        btn_ss = 1'b0;
        btn_lap = 1'b0;
        sec_in = 6'd0;
        min_in = 6'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_state", 32'(state), 0);
        check("rst_pulses", {sw_start, sw_stop, sw_clear}, 0);
        check("rst_lap", 32'(lap_active), 0);
        check("rst_disp", {disp_min, disp_sec}, 0);

        // debounce latency: start pulse only after edge 7
        @(negedge clk);
        btn_ss = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            check($sformatf("lat_start_e%0d", i), 32'(sw_start), 32'(i == 7));
            if (i == 7) check("lat_state", 32'(state), 1);
        end
        @(negedge clk);
        btn_ss = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check("release_quiet", {sw_start, sw_stop, sw_clear}, 0);
        end
        check("run_state", 32'(state), 1);

        // 3-cycle glitch on lap is rejected
        @(negedge clk);
        btn_lap = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        btn_lap = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check("glitch_state", 32'(state), 1);
        check("glitch_cnt", 32'(dut.deb_cnt[1]), 0);
        check("glitch_lap", 32'(lap_active), 0);

        // lap snapshot freezes display
        sec_in = 6'd12;
        min_in = 6'd3;
        press(1'b0, 1'b1, n_st, n_sp, n_cl);
        check("lap_pulses", 32'(n_st + n_sp + n_cl), 0);
        @(negedge clk);
        sec_in = 6'd20;
        repeat (2) @(posedge clk);
        #1;
        check("lap_state", 32'(state), 2);
        check("lap_active", 32'(lap_active), 1);
        check("lap_disp_sec", 32'(disp_sec), 12);
        check("lap_disp_min", 32'(disp_min), 3);
        press(1'b0, 1'b1, n_st, n_sp, n_cl);
        check("unlap_pulses", 32'(n_st + n_sp + n_cl), 0);
        check("unlap_state", 32'(state), 1);
        check("unlap_active", 32'(lap_active), 0);
        @(negedge clk);
        sec_in = 6'd21;
        @(posedge clk); #1;
        check("track_sec", 32'(disp_sec), 21);

        // stop, clear from PAUSED, clear again in IDLE
        press(1'b1, 1'b0, n_st, n_sp, n_cl);
        check("stop_n", 32'(n_sp), 1);
        check("stop_other", 32'(n_st + n_cl), 0);
        check("paused_state", 32'(state), 3);
        press(1'b0, 1'b1, n_st, n_sp, n_cl);
        check("clr1_n", 32'(n_cl), 1);
        check("clr1_state", 32'(state), 0);
        press(1'b0, 1'b1, n_st, n_sp, n_cl);
        check("clr2_n", 32'(n_cl), 1);
        check("clr2_other", 32'(n_st + n_sp), 0);
        check("clr2_state", 32'(state), 0);

        // simultaneous presses in RUN: start/stop wins
        press(1'b1, 1'b0, n_st, n_sp, n_cl);
        check("restart_n", 32'(n_st), 1);
        check("restart_state", 32'(state), 1);
        press(1'b1, 1'b1, n_st, n_sp, n_cl);
        check("both_stop", 32'(n_sp), 1);
        check("both_other", 32'(n_st + n_cl), 0);
        check("both_state", 32'(state), 3);
        check("both_lap", 32'(lap_active), 0);

        // async reset in the middle of LAP
        press(1'b1, 1'b0, n_st, n_sp, n_cl);
        sec_in = 6'd5;
        min_in = 6'd1;
        press(1'b0, 1'b1, n_st, n_sp, n_cl);
        @(negedge clk);
        sec_in = 6'd40;
        @(posedge clk); #1;
        check("frz_state", 32'(state), 2);
        check("frz_disp", {disp_min, disp_sec}, {6'd1, 6'd5});
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("mrst_state", 32'(state), 0);
        check("mrst_pulses", {sw_start, sw_stop, sw_clear}, 0);
        check("mrst_lap", 32'(lap_active), 0);
        check("mrst_disp", {disp_min, disp_sec}, 0);
        @(negedge clk);
        rst = 1'b0;
        sec_in = 6'd0;
        min_in = 6'd0;

        // 59:59 limit
        press(1'b1, 1'b0, n_st, n_sp, n_cl);
        check("lim_run", 32'(state), 1);
        @(negedge clk);
        sec_in = 6'd59;
        min_in = 6'd59;
        @(posedge clk); #1;
`ifdef STOPWATCH_CTRL_AUTOSTOP_EN
        check("lim_stop", 32'(sw_stop), 1);
        check("lim_state", 32'(state), 3);
`else
        check("lim_stop", 32'(sw_stop), 0);
        check("lim_state", 32'(state), 1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
